id_scoreboard: RTL and testbench
================================

ID_SCOREBOARD -- requirements
Module: id_scoreboard

Interface
REQ-001 SHALL provide parameters: NREG 32 (architectural registers), AW 5 (register address width), DW 32 (data width), NFWD 3 (forwarding sources, index 0 youngest), CW 2 (pending-counter width).
REQ-002 SHALL provide ports: clk in 1 clock; rst in 1 reset, asynchronous, active-low.
REQ-003 SHALL provide: id_valid in 1 ID holds a valid instruction; id_rs1/id_rs2 in AW source addresses; id_rs1_used/id_rs2_used in 1 source actually read.
REQ-004 SHALL provide: id_dest in AW destination; id_gr_we in 1 writes GR; ex_allowin in 1 EX accepts.
REQ-005 SHALL provide: rf_rdata1/rf_rdata2 in DW register-file read data; fwd_valid in NFWD; fwd_addr in NFWD*AW; fwd_data in NFWD*DW; fwd_data_ok in NFWD, result already computed.
REQ-006 SHALL provide: wb_valid in 1, wb_addr in AW, register-file write retiring; sb_clear in 1 drain all pending state.
REQ-007 SHALL provide: stall out 1; issue_fire out 1; rs1_value/rs2_value out DW resolved operands; sb_full out 1; sb_err out 1 sticky underflow flag.

Function
REQ-008 SHALL hold one CW-bit pending counter per register 1..NREG-1; register 0 never pending, never forwarded, value always 0.
REQ-009 SHALL compute issue_fire = id_valid & ex_allowin & ~stall, combinationally.
REQ-010 SHALL, per used source s != 0, select the lowest-index fwd source with fwd_valid & fwd_addr==s; if found and fwd_data_ok, operand = that fwd_data; if found and not ok, source is blocked.
REQ-011 SHALL, if no fwd source matches and pending[s] != 0, treat source as blocked (writer between last fwd stage and WB); if pending[s]==0, operand = rf_rdata.
REQ-012 SHALL assert stall when id_valid and (any used source blocked or sb_full); unused sources never stall.
REQ-013 SHALL assert sb_full when id_gr_we, id_dest != 0 and pending[id_dest] == 2^CW-1.
REQ-014 SHALL on clock edge increment pending[id_dest] when issue_fire & id_gr_we & id_dest != 0.
REQ-015 SHALL on clock edge decrement pending[wb_addr] when wb_valid & wb_addr != 0 and counter non-zero.
REQ-016 SHALL leave counter unchanged when increment and decrement hit the same register in one cycle, including when that counter is saturated.
REQ-017 SHALL on wb_valid to a zero counter leave it zero and set sb_err; sb_err cleared only by reset.
REQ-018 SHALL on sb_clear zero all counters next edge, overriding same-cycle increment/decrement; stall evaluation that cycle uses pre-clear state.
REQ-019 SHALL add zero cycles of latency: operand values and stall valid in the same cycle as inputs.

Reset
REQ-020 SHALL on rst low asynchronously zero all counters and sb_err; stall/issue_fire then follow REQ-009/012 with all counters zero.
REQ-021 SHALL sample rst deassertion synchronously to clk; reset mid-operation discards all pending state.

Structure
REQ-022 SHALL place NREG, AW, DW, NFWD, CW defaults and the fwd-bus packing order in shared package cpu_pkg.
REQ-023 SHALL implement per-operand priority select/block logic as sub-module sb_fwd_mux, instantiated twice (rs1, rs2).

Verification
REQ-024 Load-use: issue ld to r5; next cycle fwd[0]=(1,5,x,ok=0), ID uses r5 -> stall=1, issue_fire=0; fwd ok=1 data 0x1234 -> stall=0, rs1_value=0x1234.
REQ-025 Priority: fwd[0]=(r7,0xA,ok), fwd[2]=(r7,0xB,ok), pending[7]=2 -> rs1_value=0xA, stall=0.
REQ-026 Saturation: three issues to r3 without WB -> pending[3]=3; fourth writer to r3 -> sb_full=1, stall=1; same cycle wb_valid r3 -> counter stays 3, still stalled that cycle.
REQ-027 Register 0: id_rs1=0, dest=0, fwd[0]=(r0,0xFF,ok=0) -> rs1_value=0, stall=0, no counter change.
REQ-028 Underflow/clear: wb_valid r9 with pending[9]=0 -> sb_err=1, counter 0; sb_clear with counters non-zero -> all 0 next cycle, sb_err stays 1 until rst low.
REQ-029 Async reset: rst low between edges -> counters and sb_err zero immediately, before the next clk edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared defaults for the ID-stage scoreboard and its forwarding muxes.
// Forwarding buses pack source i at bits [i*W +: W]; source 0 is the youngest stage.
package cpu_pkg;
  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int NFWD = 3;
  localparam int CW   = 2;

  typedef enum logic [1:0] {
    SRC_ZERO = 2'd0,
    SRC_FWD  = 2'd1,
    SRC_RF   = 2'd2
  } op_src_e;
endpackage

// File: rtl/sb_fwd_mux.sv
// Resolves one source operand: youngest matching forward source wins, otherwise
// the register file, blocking when the chosen value is not yet available.
module sb_fwd_mux
  import cpu_pkg::*;
#(
  parameter int AW   = cpu_pkg::AW,
  parameter int DW   = cpu_pkg::DW,
  parameter int NFWD = cpu_pkg::NFWD
) (
  input  logic [AW-1:0]      src,
  input  logic               used,
  input  logic               pending_nz,
  input  logic [DW-1:0]      rf_rdata,
  input  logic [NFWD-1:0]    fwd_valid,
  input  logic [NFWD*AW-1:0] fwd_addr,
  input  logic [NFWD*DW-1:0] fwd_data,
  input  logic [NFWD-1:0]    fwd_data_ok,
  output logic [DW-1:0]      value,
  output logic               blocked
);
  logic [NFWD-1:0] hit;
  logic [DW-1:0]   sel_data;
  logic            sel_ok;
  op_src_e         sel;

  generate
    for (genvar gi = 0; gi < NFWD; gi++) begin : g_hit
      assign hit[gi] = fwd_valid[gi] && (fwd_addr[gi*AW +: AW] == src);
    end
  endgenerate

  // Scan oldest to youngest so the lowest matching index is the one that sticks.
  always_comb begin
    sel_data = '0;
    sel_ok   = 1'b0;
    for (int i = NFWD - 1; i >= 0; i--) begin
      if (hit[i]) begin
        sel_data = fwd_data[i*DW +: DW];
        sel_ok   = fwd_data_ok[i];
      end
    end
  end

  always_comb begin
    if (src == '0)  sel = SRC_ZERO;
    else if (|hit)  sel = SRC_FWD;
    else            sel = SRC_RF;
  end

  always_comb begin
    value   = '0;
    blocked = 1'b0;
    unique case (sel)
      SRC_FWD: begin
        value   = sel_data;
        blocked = used && !sel_ok;
      end
      SRC_RF: begin
        value   = rf_rdata;
        blocked = used && pending_nz;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/id_scoreboard.sv
// ID-stage scoreboard: per-register pending-writer counters plus operand
// forwarding, producing a same-cycle stall/issue decision.
module id_scoreboard
  import cpu_pkg::*;
#(
  parameter int NREG = cpu_pkg::NREG,
  parameter int AW   = cpu_pkg::AW,
  parameter int DW   = cpu_pkg::DW,
  parameter int NFWD = cpu_pkg::NFWD,
  parameter int CW   = cpu_pkg::CW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic [AW-1:0]      id_rs1,
  input  logic [AW-1:0]      id_rs2,
  input  logic               id_rs1_used,
  input  logic               id_rs2_used,
  input  logic [AW-1:0]      id_dest,
  input  logic               id_gr_we,
  input  logic               ex_allowin,
  input  logic [DW-1:0]      rf_rdata1,
  input  logic [DW-1:0]      rf_rdata2,
  input  logic [NFWD-1:0]    fwd_valid,
  input  logic [NFWD*AW-1:0] fwd_addr,
  input  logic [NFWD*DW-1:0] fwd_data,
  input  logic [NFWD-1:0]    fwd_data_ok,
  input  logic               wb_valid,
  input  logic [AW-1:0]      wb_addr,
  input  logic               sb_clear,
  output logic               stall,
  output logic               issue_fire,
  output logic [DW-1:0]      rs1_value,
  output logic [DW-1:0]      rs2_value,
  output logic               sb_full,
  output logic               sb_err
);
  localparam logic [CW-1:0] CNT_MAX = '1;

  logic [1:0]    rst_sync_reg;
  logic          rst_int_n;
  logic [CW-1:0] pend_reg [NREG];
  logic          sb_err_reg;
  logic          blk1, blk2;
  logic          inc_en, dec_en, hold_en, underflow;
  logic [NREG-1:1] inc_hit, dec_hit, hold_hit;

  // Assert immediately, release two edges after rst rises.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync_reg <= '0;
    else      rst_sync_reg <= {rst_sync_reg[0], 1'b1};
  end
  assign rst_int_n = rst_sync_reg[1];

  sb_fwd_mux #(.AW(AW), .DW(DW), .NFWD(NFWD)) u_mux_rs1 (
    .src(id_rs1), .used(id_rs1_used), .pending_nz(pend_reg[id_rs1] != '0),
    .rf_rdata(rf_rdata1), .fwd_valid(fwd_valid), .fwd_addr(fwd_addr),
    .fwd_data(fwd_data), .fwd_data_ok(fwd_data_ok), .value(rs1_value), .blocked(blk1)
  );

  sb_fwd_mux #(.AW(AW), .DW(DW), .NFWD(NFWD)) u_mux_rs2 (
    .src(id_rs2), .used(id_rs2_used), .pending_nz(pend_reg[id_rs2] != '0),
    .rf_rdata(rf_rdata2), .fwd_valid(fwd_valid), .fwd_addr(fwd_addr),
    .fwd_data(fwd_data), .fwd_data_ok(fwd_data_ok), .value(rs2_value), .blocked(blk2)
  );

  assign sb_full    = id_gr_we && (id_dest != '0) && (pend_reg[id_dest] == CNT_MAX);
  assign stall      = id_valid && (blk1 || blk2 || sb_full);
  assign issue_fire = id_valid && ex_allowin && !stall;

  assign inc_en    = issue_fire && id_gr_we && (id_dest != '0);
  assign dec_en    = wb_valid && (wb_addr != '0) && (pend_reg[wb_addr] != '0);
  assign underflow = wb_valid && (wb_addr != '0) && (pend_reg[wb_addr] == '0);
  // A writer held back only by saturation still cancels a same-register retire.
  assign hold_en   = id_valid && id_gr_we && (id_dest != '0) && (issue_fire || sb_full);

  generate
    for (genvar gi = 1; gi < NREG; gi++) begin : g_hit
      assign inc_hit[gi]  = inc_en  && (id_dest == AW'(gi));
      assign dec_hit[gi]  = dec_en  && (wb_addr == AW'(gi));
      assign hold_hit[gi] = hold_en && (id_dest == AW'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      for (int i = 0; i < NREG; i++) pend_reg[i] <= '0;
      sb_err_reg <= 1'b0;
    end else begin
      if (underflow) sb_err_reg <= 1'b1;
      for (int i = 1; i < NREG; i++) begin
        if (sb_clear)                       pend_reg[i] <= '0;
        else if (dec_hit[i] && hold_hit[i]) pend_reg[i] <= pend_reg[i];
        else if (inc_hit[i])                pend_reg[i] <= pend_reg[i] + 1'b1;
        else if (dec_hit[i])                pend_reg[i] <= pend_reg[i] - 1'b1;
      end
    end
  end

  assign sb_err = sb_err_reg;
endmodule

// File: tb/tb_id_scoreboard.sv
// Self-checking bench for id_scoreboard: directed scenarios followed by
// randomized traffic compared against a per-register pending-count model.
module tb_id_scoreboard;
  localparam int AW = 5, DW = 32, NFWD = 3, MAXC = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic id_valid, id_rs1_used, id_rs2_used, id_gr_we, ex_allowin;
  logic [AW-1:0] id_rs1, id_rs2, id_dest, wb_addr;
  logic [DW-1:0] rf_rdata1, rf_rdata2, rs1_value, rs2_value;
  logic [NFWD-1:0] fwd_valid, fwd_data_ok;
  logic [NFWD*AW-1:0] fwd_addr;
  logic [NFWD*DW-1:0] fwd_data;
  logic wb_valid, sb_clear, stall, issue_fire, sb_full, sb_err;

  bit          fv[NFWD];
  int          fa[NFWD];
  logic [31:0] fd[NFWD];
  bit          fo[NFWD];

  int pend[32];
  bit err_m;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_scoreboard dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_dest(id_dest),
    .id_gr_we(id_gr_we), .ex_allowin(ex_allowin), .rf_rdata1(rf_rdata1),
    .rf_rdata2(rf_rdata2), .fwd_valid(fwd_valid), .fwd_addr(fwd_addr),
    .fwd_data(fwd_data), .fwd_data_ok(fwd_data_ok), .wb_valid(wb_valid),
    .wb_addr(wb_addr), .sb_clear(sb_clear), .stall(stall), .issue_fire(issue_fire),
    .rs1_value(rs1_value), .rs2_value(rs2_value), .sb_full(sb_full), .sb_err(sb_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
    id_dest = 0; id_gr_we = 0; ex_allowin = 1; wb_valid = 0; wb_addr = 0; sb_clear = 0;
    rf_rdata1 = $urandom; rf_rdata2 = $urandom;
    for (int k = 0; k < NFWD; k++) begin fv[k] = 0; fa[k] = 0; fd[k] = 0; fo[k] = 0; end
  endtask

  task automatic drive();
    for (int k = 0; k < NFWD; k++) begin
      fwd_valid[k] = fv[k];
      fwd_addr[k*AW +: AW] = fa[k][AW-1:0];
      fwd_data[k*DW +: DW] = fd[k];
      fwd_data_ok[k] = fo[k];
    end
  endtask

  // Operand resolution from the rules: reg 0 reads zero, youngest forward wins, else RF.
  function automatic void exp_src(input int s, input bit used, input logic [31:0] rf,
                                  output bit blk, output logic [31:0] val);
    int hit = -1;
    blk = 0;
    val = 0;
    if (s == 0) return;
    for (int k = 0; k < NFWD; k++) if (hit < 0 && fv[k] && fa[k] == s) hit = k;
    if (hit >= 0) begin val = fd[hit]; blk = used && !fo[hit]; end
    else begin val = rf; blk = used && pend[s] != 0; end
  endfunction

  task automatic reset_model();
    for (int r = 0; r < 32; r++) pend[r] = 0;
    err_m = 0;
  endtask

  // Check all outputs for the current inputs, then advance one clock and the model.
  task automatic step(input string tag);
    bit b1, b2, full, stl, fire, hold;
    logic [31:0] v1, v2;
    int d, w;
    int nxt[32];
    drive();
    #1;
    exp_src(int'(id_rs1), id_rs1_used, rf_rdata1, b1, v1);
    exp_src(int'(id_rs2), id_rs2_used, rf_rdata2, b2, v2);
    d = int'(id_dest);
    w = int'(wb_addr);
    full = id_gr_we && d != 0 && pend[d] == MAXC;
    stl  = id_valid && (b1 || b2 || full);
    fire = id_valid && ex_allowin && !stl;
    check({tag, ".stall"}, stall, stl);
    check({tag, ".fire"}, issue_fire, fire);
    check({tag, ".full"}, sb_full, full);
    check({tag, ".err"}, sb_err, err_m);
    if (id_rs1_used && !b1) check({tag, ".rs1"}, rs1_value, v1);
    if (id_rs2_used && !b2) check({tag, ".rs2"}, rs2_value, v2);
    nxt = pend;
    hold = id_valid && id_gr_we && d != 0 && (fire || full);
    if (wb_valid && w != 0 && pend[w] == 0) err_m = 1;
    if (sb_clear) begin
      for (int r = 0; r < 32; r++) nxt[r] = 0;
    end else if (!(hold && wb_valid && w != 0 && w == d && pend[w] > 0)) begin
      if (fire && id_gr_we && d != 0) nxt[d]++;
      if (wb_valid && w != 0 && pend[w] > 0) nxt[w]--;
    end
    @(posedge clk);
    pend = nxt;
    #1;
  endtask

  task automatic issue(input int r);
    idle(); id_valid = 1; id_gr_we = 1; id_dest = AW'(r);
    step("issue");
  endtask

  task automatic retire(input int r);
    idle(); wb_valid = 1; wb_addr = AW'(r);
    step("retire");
  endtask

  initial begin
    idle();
    drive();
    reset_model();
    #12;
    check("rst.err", sb_err, 0);
    check("rst.stall", stall, 0);
    check("rst.fire", issue_fire, 0);
    rst = 1;
    repeat (3) @(posedge clk);
    #1;

    // Load-use through the youngest forward stage.
    issue(5);
    idle(); id_valid = 1; id_rs1 = 5; id_rs1_used = 1;
    fv[0] = 1; fa[0] = 5; fd[0] = 32'hDEAD; fo[0] = 0;
    drive(); #1;
    check("lu.stall", stall, 1);
    check("lu.fire", issue_fire, 0);
    step("lu_wait");
    idle(); id_valid = 1; id_rs1 = 5; id_rs1_used = 1;
    fv[0] = 1; fa[0] = 5; fd[0] = 32'h1234; fo[0] = 1;
    drive(); #1;
    check("lu.ok_stall", stall, 0);
    check("lu.ok_rs1", rs1_value, 32'h1234);
    step("lu_ok");
    retire(5);

    // Youngest forward source beats an older one and the pending count.
    issue(7); issue(7);
    idle(); id_valid = 1; id_rs1 = 7; id_rs1_used = 1;
    fv[0] = 1; fa[0] = 7; fd[0] = 32'hA; fo[0] = 1;
    fv[2] = 1; fa[2] = 7; fd[2] = 32'hB; fo[2] = 1;
    drive(); #1;
    check("prio.rs1", rs1_value, 32'hA);
    check("prio.stall", stall, 0);
    step("prio");
    retire(7); retire(7);

    // Saturation of r3, with a same-cycle retire that must not move the counter.
    issue(3); issue(3); issue(3);
    idle(); id_valid = 1; id_gr_we = 1; id_dest = 3; wb_valid = 1; wb_addr = 3;
    drive(); #1;
    check("sat.full", sb_full, 1);
    check("sat.stall", stall, 1);
    step("sat_wb");
    idle(); id_valid = 1; id_gr_we = 1; id_dest = 3;
    drive(); #1;
    check("sat.still_full", sb_full, 1);
    step("sat_hold");
    retire(3); retire(3); retire(3);

    // Register 0 is never pending nor forwarded.
    idle(); id_valid = 1; id_rs1 = 0; id_rs1_used = 1; id_gr_we = 1; id_dest = 0;
    fv[0] = 1; fa[0] = 0; fd[0] = 32'hFF; fo[0] = 0;
    drive(); #1;
    check("r0.rs1", rs1_value, 0);
    check("r0.stall", stall, 0);
    step("r0");

    // Underflow sets the sticky error; clear drains every counter.
    retire(9);
    check("uf.err", sb_err, 1);
    issue(4); issue(4); issue(6);
    idle(); sb_clear = 1; wb_valid = 1; wb_addr = 6;
    step("clear");
    idle(); id_valid = 1; id_rs1 = 4; id_rs1_used = 1; id_rs2 = 6; id_rs2_used = 1;
    drive(); #1;
    check("clr.stall", stall, 0);
    check("clr.err", sb_err, 1);
    step("after_clear");

    // Randomized traffic over a handful of registers to force collisions.
    for (int n = 0; n < 400; n++) begin
      idle();
      id_valid    = ($urandom_range(0, 3) != 0);
      ex_allowin  = ($urandom_range(0, 4) != 0);
      id_rs1      = AW'($urandom_range(0, 4));
      id_rs2      = AW'($urandom_range(0, 4));
      id_rs1_used = $urandom_range(0, 1);
      id_rs2_used = $urandom_range(0, 1);
      id_gr_we    = $urandom_range(0, 1);
      id_dest     = AW'($urandom_range(0, 4));
      wb_valid    = ($urandom_range(0, 2) == 0);
      wb_addr     = AW'($urandom_range(0, 4));
      sb_clear    = ($urandom_range(0, 31) == 0);
      for (int k = 0; k < NFWD; k++) begin
        fv[k] = ($urandom_range(0, 2) == 0);
        fa[k] = $urandom_range(0, 4);
        fd[k] = $urandom;
        fo[k] = $urandom_range(0, 1);
      end
      step($sformatf("rnd%0d", n));
    end

    // Asynchronous reset between edges takes effect before the next edge.
    retire(12);
    issue(2);
    idle(); id_valid = 1; id_rs1 = 2; id_rs1_used = 1;
    drive(); #1;
    check("ar.pre_stall", stall, 1);
    check("ar.pre_err", sb_err, 1);
    rst = 0;
    #1;
    check("ar.stall", stall, 0);
    check("ar.err", sb_err, 0);
    reset_model();
    @(posedge clk); #2;
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    step("post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
